// File: rtl/cpu_pkg.sv
// Shared core package: ISA constants used by fetch queue and decode/imm stage.
// Holds NOP encoding, XLEN and base opcode values.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [6:0] {
    R_TYPE = 7'b0110011,
    I_TYPE = 7'b0010011,
    S_TYPE = 7'b0100011,
    U_TYPE = 7'b0110111
  } opcode_e;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch->decode queue bundle: fetch push side, decode pop side, flush, count.
// master = fetch/decode/control side, slave = the queue itself.
interface instr_fetch_queue_if #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic            flush;
  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] fetch_instr;
  logic [XLEN-1:0] fetch_pc;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_instr;
  logic [XLEN-1:0] dec_pc;
  logic [CW-1:0]   count;

  modport master (
    output flush,
    output fetch_valid,
    output fetch_instr,
    output fetch_pc,
    output dec_ready,
    input  fetch_ready,
    input  dec_valid,
    input  dec_instr,
    input  dec_pc,
    input  count
  );

  modport slave (
    input  flush,
    input  fetch_valid,
    input  fetch_instr,
    input  fetch_pc,
    input  dec_ready,
    output fetch_ready,
    output dec_valid,
    output dec_instr,
    output dec_pc,
    output count
  );

endinterface

// File: rtl/instr_fetch_queue.sv
// Circular FIFO of {pc, instr} between fetch and decode, with 1-cycle flush.
// Ports: clk, rst_n (async low), bus (slave): fetch_*, dec_*, flush, count.
module instr_fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input logic               clk,
  input logic               rst_n,
  instr_fetch_queue_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2*XLEN-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  assign push = bus.fetch_valid & ~full & ~bus.flush;
  assign pop  = ~empty & bus.dec_ready & ~bus.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: empty masks whatever it holds.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.fetch_pc, bus.fetch_instr};
  end

  logic [2*XLEN-1:0] head;

  assign head = mem_q[rd_ptr_q];

  assign bus.fetch_ready = ~full;
  assign bus.dec_valid   = ~empty;
  assign bus.dec_pc      = empty ? '0 : head[2*XLEN-1:XLEN];
  assign bus.dec_instr   = empty ? XLEN'(NOP_INSTR) : head[XLEN-1:0];
  assign bus.count       = count_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: order, full, stream, flush, reset.
// Expected values are hand-derived constants per step.
module tb_instr_fetch_queue;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_n;

  int passed = 0;
  int total  = 0;

  instr_fetch_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

  instr_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_valid"}, 64'(bus.dec_valid), 64'd0);
    chk({tag, "_ready"}, 64'(bus.fetch_ready), 64'd1);
    chk({tag, "_count"}, 64'(bus.count), 64'd0);
    chk({tag, "_instr"}, 64'(bus.dec_instr), 64'(NOP));
    chk({tag, "_pc"}, 64'(bus.dec_pc), 64'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.flush       = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.fetch_instr = '0;
    bus.fetch_pc    = '0;
    bus.dec_ready   = 1'b0;

    // Reset
    #12;
    chk_reset_outs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Ordering: fill 8 entries without popping
    for (int i = 0; i < 8; i++) begin
      bus.fetch_valid = 1'b1;
      bus.fetch_pc    = 32'(i * 4);
      bus.fetch_instr = 32'h00A0_0093 + 32'(i);
      step();
      if (i == 0) begin
        chk("lat_valid", 64'(bus.dec_valid), 64'd1);
        chk("lat_pc", 64'(bus.dec_pc), 64'd0);
      end
    end
    chk("fill_count", 64'(bus.count), 64'd8);
    chk("fill_ready", 64'(bus.fetch_ready), 64'd0);
    chk("fill_head_pc", 64'(bus.dec_pc), 64'd0);
    chk("fill_head_in", 64'(bus.dec_instr), 64'h00A0_0093);

    // Full: push attempt with pop in same cycle is refused
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = 32'h20;
    bus.fetch_instr = 32'h00A0_009B;
    bus.dec_ready   = 1'b1;
    step();
    chk("full_count", 64'(bus.count), 64'd7);
    chk("full_ready", 64'(bus.fetch_ready), 64'd1);
    chk("full_pc", 64'(bus.dec_pc), 64'h4);
    bus.dec_ready = 1'b0;
    step();
    chk("retry_count", 64'(bus.count), 64'd8);
    bus.fetch_valid = 1'b0;
    bus.dec_ready   = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("ord_pc%0d", k), 64'(bus.dec_pc), 64'(k * 4));
      chk($sformatf("ord_in%0d", k), 64'(bus.dec_instr),
          64'(32'h00A0_0093 + 32'(k)));
      step();
    end
    chk("drain_count", 64'(bus.count), 64'd0);
    chk("drain_valid", 64'(bus.dec_valid), 64'd0);
    chk("drain_instr", 64'(bus.dec_instr), 64'(NOP));

    // dec_ready while empty is ignored
    step();
    chk("empty_pop", 64'(bus.count), 64'd0);
    bus.dec_ready = 1'b0;

    // Steady stream at count=3, pointers wrap
    for (int j = 0; j < 3; j++) begin
      bus.fetch_valid = 1'b1;
      bus.fetch_pc    = 32'h100 + 32'(4 * j);
      bus.fetch_instr = 32'h1000 + 32'(j);
      step();
    end
    chk("strm_count0", 64'(bus.count), 64'd3);
    bus.dec_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.fetch_pc    = 32'h100 + 32'(4 * (c + 3));
      bus.fetch_instr = 32'h1000 + 32'(c + 3);
      chk($sformatf("strm_pc%0d", c), 64'(bus.dec_pc),
          64'(32'h100 + 32'(4 * c)));
      step();
      chk($sformatf("strm_cnt%0d", c), 64'(bus.count), 64'd3);
    end
    bus.fetch_valid = 1'b0;
    for (int c = 20; c < 23; c++) begin
      chk($sformatf("strm_in%0d", c), 64'(bus.dec_instr),
          64'(32'h1000 + 32'(c)));
      step();
    end
    chk("strm_empty", 64'(bus.dec_valid), 64'd0);
    bus.dec_ready = 1'b0;

    // Flush with push and pop requested
    for (int j = 0; j < 5; j++) begin
      bus.fetch_valid = 1'b1;
      bus.fetch_pc    = 32'h200 + 32'(4 * j);
      bus.fetch_instr = 32'h2000 + 32'(j);
      step();
    end
    chk("fl_count5", 64'(bus.count), 64'd5);
    bus.flush       = 1'b1;
    bus.fetch_pc    = 32'h300;
    bus.fetch_instr = 32'h3000;
    bus.dec_ready   = 1'b1;
    step();
    bus.flush       = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.dec_ready   = 1'b0;
    chk("fl_count", 64'(bus.count), 64'd0);
    chk("fl_valid", 64'(bus.dec_valid), 64'd0);
    chk("fl_pc", 64'(bus.dec_pc), 64'd0);
    step();
    chk("fl_stay", 64'(bus.dec_valid), 64'd0);
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = 32'h400;
    bus.fetch_instr = 32'h4000;
    step();
    bus.fetch_valid = 1'b0;
    chk("fl_new_pc", 64'(bus.dec_pc), 64'h400);
    chk("fl_new_cnt", 64'(bus.count), 64'd1);
    bus.dec_ready = 1'b1;
    step();
    bus.dec_ready = 1'b0;
    chk("fl_new_pop", 64'(bus.count), 64'd0);

    // Async reset mid-stream
    for (int j = 0; j < 4; j++) begin
      bus.fetch_valid = 1'b1;
      bus.fetch_pc    = 32'h500 + 32'(4 * j);
      bus.fetch_instr = 32'h5000 + 32'(j);
      step();
    end
    bus.fetch_valid = 1'b0;
    chk("ar_count4", 64'(bus.count), 64'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("arst");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = 32'h600;
    bus.fetch_instr = 32'h6000;
    step();
    bus.fetch_valid = 1'b0;
    chk("ar_cnt", 64'(bus.count), 64'd1);
    chk("ar_pc", 64'(bus.dec_pc), 64'h600);
    chk("ar_in", 64'(bus.dec_instr), 64'h6000);
    bus.dec_ready = 1'b1;
    step();
    bus.dec_ready = 1'b0;
    chk("ar_pop_cnt", 64'(bus.count), 64'd0);
    chk("ar_pop_vld", 64'(bus.dec_valid), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
